// File: rtl/sc_life_pkg.sv
// sc_life_pkg: shared state codes, widths and default timing constants for the game-flow controller
package sc_life_pkg;
  localparam int STATEWIDTH = 3;
  typedef enum logic [STATEWIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_DYING    = 3'd3,
    ST_RESPAWN  = 3'd4,
    ST_GAMEOVER = 3'd5,
    ST_NEWGAME  = 3'd6
  } state_e;
  localparam logic [1:0] LIVES_FULL = 2'b11;
  localparam int unsigned TICKWIDTH_DEF   = 26;
  localparam int unsigned DEATH_TICKS_DEF = 50000000;
  localparam int unsigned GRACE_TICKS_DEF = 25000000;
  function automatic logic is_frozen(state_e s);
    return s inside {ST_IDLE, ST_HIT, ST_DYING, ST_NEWGAME, ST_GAMEOVER};
  endfunction
endpackage

// File: rtl/sc_life_controller_if.sv
// sc_life_controller_if: detector/life-counter inputs and game-flow outputs of the life controller
interface sc_life_controller_if #(
  parameter int DATAWIDTH_2 = 2
);
  logic                   SC_LIFE_CONTROLLER_START_InLow;
  logic                   SC_LIFE_CONTROLLER_COLLISION_InHigh;
  logic                   SC_LIFE_CONTROLLER_GOAL_InHigh;
  logic [DATAWIDTH_2-1:0] SC_LIFE_CONTROLLER_LIVES_InBUS;
  logic                   SC_LIFE_CONTROLLER_CUENTA_OutLow;
  logic                   SC_LIFE_CONTROLLER_RESETLIVES_OutHigh;
  logic                   SC_LIFE_CONTROLLER_RESPAWN_OutHigh;
  logic                   SC_LIFE_CONTROLLER_FREEZE_OutHigh;
  logic                   SC_LIFE_CONTROLLER_GAMEOVER_OutHigh;
  logic [2:0]             SC_LIFE_CONTROLLER_STATE_OutBUS;
  modport master (
    output SC_LIFE_CONTROLLER_START_InLow, SC_LIFE_CONTROLLER_COLLISION_InHigh,
           SC_LIFE_CONTROLLER_GOAL_InHigh, SC_LIFE_CONTROLLER_LIVES_InBUS,
    input  SC_LIFE_CONTROLLER_CUENTA_OutLow, SC_LIFE_CONTROLLER_RESETLIVES_OutHigh,
           SC_LIFE_CONTROLLER_RESPAWN_OutHigh, SC_LIFE_CONTROLLER_FREEZE_OutHigh,
           SC_LIFE_CONTROLLER_GAMEOVER_OutHigh, SC_LIFE_CONTROLLER_STATE_OutBUS
  );
  modport slave (
    input  SC_LIFE_CONTROLLER_START_InLow, SC_LIFE_CONTROLLER_COLLISION_InHigh,
           SC_LIFE_CONTROLLER_GOAL_InHigh, SC_LIFE_CONTROLLER_LIVES_InBUS,
    output SC_LIFE_CONTROLLER_CUENTA_OutLow, SC_LIFE_CONTROLLER_RESETLIVES_OutHigh,
           SC_LIFE_CONTROLLER_RESPAWN_OutHigh, SC_LIFE_CONTROLLER_FREEZE_OutHigh,
           SC_LIFE_CONTROLLER_GAMEOVER_OutHigh, SC_LIFE_CONTROLLER_STATE_OutBUS
  );
endinterface

// File: rtl/sc_tick_timer.sv
// sc_tick_timer: loadable down-counter that stops at zero; load has priority over counting
module sc_tick_timer #(
  parameter int TICKWIDTH = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [TICKWIDTH-1:0] load_val_i,
  output logic                 zero_o
);
  logic [TICKWIDTH-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i :
                        (en_i && count_q != '0) ? count_q - TICKWIDTH'(1) : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign zero_o = (count_q == '0);
endmodule

// File: rtl/sc_life_controller.sv
// sc_life_controller: Frogger game-flow FSM turning collisions into single life-decrement strobes
module sc_life_controller
  import sc_life_pkg::*;
#(
  parameter int          DATAWIDTH_2 = 2,
  parameter int          TICKWIDTH   = TICKWIDTH_DEF,
  parameter int unsigned DEATH_TICKS = DEATH_TICKS_DEF,
  parameter int unsigned GRACE_TICKS = GRACE_TICKS_DEF
) (
  input  logic                 SC_LIFE_CONTROLLER_CLOCK_50,
  input  logic                 SC_LIFE_CONTROLLER_RESET_InHigh,
  sc_life_controller_if.slave  bus
);
  state_e               state_q, state_d;
  logic                 prev_start_q, prev_start_d;
  logic                 start_edge, zero, grace, lives_zero, tmr_load, tmr_en;
  logic [TICKWIDTH-1:0] tmr_val;
  assign prev_start_d = bus.SC_LIFE_CONTROLLER_START_InLow;
  assign start_edge   = prev_start_q & ~bus.SC_LIFE_CONTROLLER_START_InLow;
  assign grace        = ~zero;
  assign lives_zero   = (bus.SC_LIFE_CONTROLLER_LIVES_InBUS == '0);
  // one timer serves both the grace window (PLAY) and the death delay (DYING)
  assign tmr_load = (state_q == ST_HIT) || (state_q == ST_RESPAWN);
  assign tmr_en   = (state_q == ST_PLAY) || (state_q == ST_DYING);
  assign tmr_val  = (state_q == ST_HIT) ? TICKWIDTH'(DEATH_TICKS - 1) : TICKWIDTH'(GRACE_TICKS);
  sc_tick_timer #(.TICKWIDTH(TICKWIDTH)) u_timer (
    .clk        (SC_LIFE_CONTROLLER_CLOCK_50),
    .rst        (SC_LIFE_CONTROLLER_RESET_InHigh),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .zero_o     (zero)
  );
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_GAMEOVER: state_d = start_edge ? ST_NEWGAME : state_q;
      ST_NEWGAME:           state_d = ST_RESPAWN;
      ST_RESPAWN:           state_d = ST_PLAY;
      ST_PLAY:              state_d = (bus.SC_LIFE_CONTROLLER_COLLISION_InHigh && !grace) ? ST_HIT :
                                      bus.SC_LIFE_CONTROLLER_GOAL_InHigh ? ST_RESPAWN : ST_PLAY;
      ST_HIT:               state_d = ST_DYING;
      ST_DYING:             state_d = !zero ? ST_DYING : lives_zero ? ST_GAMEOVER : ST_RESPAWN;
      default:              state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge SC_LIFE_CONTROLLER_CLOCK_50) begin
    if (SC_LIFE_CONTROLLER_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      prev_start_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      prev_start_q <= prev_start_d;
    end
  end
  // strobe is withheld at zero lives so the external counter cannot wrap to 3
  assign bus.SC_LIFE_CONTROLLER_CUENTA_OutLow      = ~((state_q == ST_HIT) && !lives_zero);
  assign bus.SC_LIFE_CONTROLLER_RESETLIVES_OutHigh = (state_q == ST_NEWGAME);
  assign bus.SC_LIFE_CONTROLLER_RESPAWN_OutHigh    = (state_q == ST_RESPAWN);
  assign bus.SC_LIFE_CONTROLLER_FREEZE_OutHigh     = is_frozen(state_q);
  assign bus.SC_LIFE_CONTROLLER_GAMEOVER_OutHigh   = (state_q == ST_GAMEOVER);
  assign bus.SC_LIFE_CONTROLLER_STATE_OutBUS       = state_q;
endmodule
